// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 single-wire receiver.
// Byte-slice localparams give the LSB index of each byte in the 40-bit frame.
package dht11_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_SYNC_L,
      ST_SYNC_H,
      ST_DATA_L,
      ST_DATA_H,
      ST_DONE
   } state_t;

   localparam int FRAME_BITS = 40;
   localparam int RH_INT     = 32;
   localparam int RH_DEC     = 24;
   localparam int T_INT      = 16;
   localparam int T_DEC      = 8;
   localparam int CSUM       = 0;

   // The checksum byte is the low 8 bits of the sum of the four data bytes.
   function automatic logic csum_ok(input logic [FRAME_BITS-1:0] f);
      logic [7:0] s;
      s = f[RH_INT +: 8] + f[RH_DEC +: 8] + f[T_INT +: 8] + f[T_DEC +: 8];
      return (s == f[CSUM +: 8]);
   endfunction

endpackage

// File: rtl/dht11_receiver_tick_gen.sv
// tick_gen_dht: one-cycle pulse every microsecond, derived from CLK_FREQ_HZ.
module tick_gen_dht #(
   parameter int CLK_FREQ_HZ = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int DIV = (CLK_FREQ_HZ / 1_000_000 < 1) ? 1 : CLK_FREQ_HZ / 1_000_000;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == CW'(DIV - 1)) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + 1'b1;
         tick <= 1'b0;
      end
   end
endmodule

// File: rtl/dht11_receiver.sv
// DHT11 receiver: drives the start pulse, decodes the 40-bit frame, owns the open-drain line.
// Define DHT11_CHECKSUM_EN to reject frames whose checksum byte does not match.
module dht11_receiver
   import dht11_pkg::*;
#(
   parameter int CLK_FREQ_HZ   = 100_000_000,
   parameter int START_US      = 18_000,
   parameter int WAIT_US       = 30,
   parameter int BIT_THRESH_US = 40,
   parameter int TIMEOUT_US    = 1_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   inout  wire                   dht_io,
   output logic [FRAME_BITS-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_busy,
   output logic                  o_error
);
   localparam int UW = 16;

   state_t                state_q, state_d;
   logic                  tick;
   logic [2:0]            sync_q;
   logic                  rise, fall;
   logic [UW-1:0]         us_cnt;
   logic [5:0]            bit_cnt;
   logic [FRAME_BITS-1:0] shreg;
   logic                  accept, shift_en, commit, timeout;
   logic                  frame_ok;

   tick_gen_dht #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Open drain: the host only ever pulls low; the external pull-up supplies the high level.
   assign dht_io = (state_q == ST_START) ? 1'b0 : 1'bz;

   assign rise = sync_q[1] & ~sync_q[2];
   assign fall = ~sync_q[1] & sync_q[2];

`ifdef DHT11_CHECKSUM_EN
   assign frame_ok = csum_ok(shreg);
`else
   assign frame_ok = 1'b1;
`endif

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      shift_en = 1'b0;
      commit   = 1'b0;
      timeout  = 1'b0;
      case (state_q)
         ST_IDLE:   if (i_start) begin
                       state_d = ST_START;
                       accept  = 1'b1;
                    end
         ST_START:  if (us_cnt >= UW'(START_US)) state_d = ST_WAIT;
         ST_WAIT:   if (us_cnt >= UW'(WAIT_US)) state_d = ST_SYNC_L;
         // A rise can only follow the sensor's response low, so it marks the end of it.
         ST_SYNC_L: if (rise) state_d = ST_SYNC_H;
         ST_SYNC_H: if (fall) state_d = ST_DATA_L;
         ST_DATA_L: if (rise) state_d = ST_DATA_H;
         ST_DATA_H: if (fall) begin
                       shift_en = 1'b1;
                       state_d  = (bit_cnt == 6'(FRAME_BITS - 1)) ? ST_DONE : ST_DATA_L;
                    end
         ST_DONE:   begin
                       commit  = 1'b1;
                       state_d = ST_IDLE;
                    end
         default:   state_d = ST_IDLE;
      endcase
      if ((state_q inside {ST_SYNC_L, ST_SYNC_H, ST_DATA_L, ST_DATA_H}) &&
          (us_cnt >= UW'(TIMEOUT_US))) begin
         timeout  = 1'b1;
         shift_en = 1'b0;
         state_d  = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sync_q  <= 3'b111;
         us_cnt  <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         o_data  <= '0;
         o_valid <= 1'b0;
         o_busy  <= 1'b0;
         o_error <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[1:0], dht_io};
         // Every state measures its own dwell, so the count restarts on each transition.
         if (state_d != state_q || state_q == ST_IDLE)
            us_cnt <= '0;
         else if (tick && us_cnt != '1)
            us_cnt <= us_cnt + 1'b1;
         o_valid <= 1'b0;
         if (accept) begin
            o_busy  <= 1'b1;
            o_error <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
         end
         if (shift_en) begin
            shreg   <= {shreg[FRAME_BITS-2:0], (us_cnt > UW'(BIT_THRESH_US))};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (commit) begin
            o_busy <= 1'b0;
            if (frame_ok) begin
               o_data  <= shreg;
               o_valid <= 1'b1;
            end else begin
               o_error <= 1'b1;
            end
         end
         if (timeout) begin
            o_busy  <= 1'b0;
            o_error <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_dht11_receiver.sv
// Bench for dht11_receiver: behavioural DHT11 sensor on a pulled-up line, frame scoreboard.
`timescale 1ns/1ps
module tb_dht11_receiver;
   localparam int CLK_FREQ_HZ   = 2_000_000;
   localparam int CYC_PER_US    = 2;
   localparam int HALF_NS       = 250;
   localparam int START_US      = 200;
   localparam int WAIT_US       = 30;
   localparam int BIT_THRESH_US = 40;
   localparam int TIMEOUT_US    = 1000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_start = 1'b0;
   logic        sensor_low = 1'b0;
   wire         dht_io;
   logic [39:0] o_data;
   logic        o_valid, o_busy, o_error;

   assign dht_io = sensor_low ? 1'b0 : 1'bz;
   pullup (dht_io);

   dht11_receiver #(
      .CLK_FREQ_HZ   (CLK_FREQ_HZ),
      .START_US      (START_US),
      .WAIT_US       (WAIT_US),
      .BIT_THRESH_US (BIT_THRESH_US),
      .TIMEOUT_US    (TIMEOUT_US)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_start (i_start),
      .dht_io  (dht_io),
      .o_data  (o_data),
      .o_valid (o_valid),
      .o_busy  (o_busy),
      .o_error (o_error)
   );

   always #HALF_NS clk = ~clk;

   logic [39:0] exp_q[$];
   logic [39:0] exp_data = '0;
   int checks = 0;
   int fails = 0;
   int valid_cnt = 0;
   int low_runs = 0;
   int last_low_len = 0;
   int cur_low = 0;

   task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard on o_valid, plus a record of every host-driven low pulse on the line.
   always @(negedge clk) begin
      if (!rst && o_valid) begin
         valid_cnt++;
         check_eq("valid_expected", 40'(exp_q.size() != 0), 40'd1);
         if (exp_q.size() != 0) check_eq("frame", o_data, exp_q.pop_front());
      end
      if (dht_io === 1'b0 && !sensor_low) cur_low++;
      else if (cur_low != 0) begin
         low_runs++;
         last_low_len = cur_low;
         cur_low = 0;
      end
   end

   task automatic wait_us(input int n);
      #(n * 1000);
   endtask

   task automatic pulse_start();
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
   endtask

   task automatic wait_idle(input int max_us, output int cycles);
      cycles = 0;
      while (o_busy !== 1'b0 && cycles < max_us * CYC_PER_US) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   function automatic logic [39:0] make_frame(input logic [7:0] b0, b1, b2, b3, input logic [7:0] corrupt);
      int s;
      s = int'(b0) + int'(b1) + int'(b2) + int'(b3);
      return {b0, b1, b2, b3, 8'(s % 256) ^ corrupt};
   endfunction

   function automatic bit model_commit(input logic [39:0] f);
      int s;
      bit ok;
      s  = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
      ok = ((s % 256) == int'(f[7:0]));
`ifndef DHT11_CHECKSUM_EN
      ok = 1'b1;
`endif
      return ok;
   endfunction

   // Sensor: wait for the host start pulse, answer 80/80 us, then 40 bits (50 us low + data high).
   task automatic sensor_frame(input logic [39:0] bits, input bit silent, input int hi0,
                               input int hi1, input int abort_bit, output bit aborted);
      int n;
      aborted = 1'b0;
      n = 0;
      while (dht_io !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
      check_eq("start_seen", 40'(dht_io === 1'b0), 40'd1);
      n = 0;
      while (dht_io !== 1'b1 && n < 4 * START_US * CYC_PER_US) begin @(negedge clk); n++; end
      if (silent) return;
      wait_us(20);
      sensor_low = 1'b1; wait_us(80);
      sensor_low = 1'b0; wait_us(80);
      for (int i = 39; i >= 0; i--) begin
         sensor_low = 1'b1; wait_us(50);
         sensor_low = 1'b0;
         if (39 - i == abort_bit) begin
            wait_us(10);
            aborted = 1'b1;
            return;
         end
         wait_us(bits[i] ? hi1 : hi0);
      end
      sensor_low = 1'b1; wait_us(50);
      sensor_low = 1'b0;
   endtask

   task automatic post_checks(input string name, input int v0, input bit commit_exp);
      check_eq({name, "_valid_cnt"}, 40'(valid_cnt - v0), commit_exp ? 40'd1 : 40'd0);
      check_eq({name, "_data"}, o_data, exp_data);
      check_eq({name, "_error"}, 40'(o_error), commit_exp ? 40'd0 : 40'd1);
      check_eq({name, "_busy"}, 40'(o_busy), 40'd0);
      check_eq({name, "_q_empty"}, 40'(exp_q.size()), 40'd0);
   endtask

   task automatic run_frame(input string name, input logic [39:0] f, input int hi0, input int hi1);
      int  v0, cyc;
      bit  ce, ab;
      v0 = valid_cnt;
      ce = model_commit(f);
      if (ce) begin
         exp_q.push_back(f);
         exp_data = f;
      end
      pulse_start();
      sensor_frame(f, 1'b0, hi0, hi1, -1, ab);
      wait_idle(2000, cyc);
      @(negedge clk);
      post_checks(name, v0, ce);
   endtask

   initial begin
      #(60_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int          v0, cyc, lr0;
      bit          ab;
      logic [39:0] f;

      repeat (5) @(negedge clk);
      check_eq("rst_data", o_data, 40'd0);
      check_eq("rst_valid", 40'(o_valid), 40'd0);
      check_eq("rst_busy", 40'(o_busy), 40'd0);
      check_eq("rst_error", 40'(o_error), 40'd0);
      check_eq("rst_line", 40'(dht_io), 40'd1);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      run_frame("t1", 40'h370018004F, 26, 70);

      // Sensor silent: timeout after WAIT_US + TIMEOUT_US from the release of the line.
      v0 = valid_cnt;
      pulse_start();
      sensor_frame(40'd0, 1'b1, 26, 70, -1, ab);
      wait_idle(3000, cyc);
      check_eq("t2_timeout_time", 40'(cyc >= (WAIT_US + TIMEOUT_US) * CYC_PER_US - 6 &&
                                      cyc <= (WAIT_US + TIMEOUT_US) * CYC_PER_US + 8), 40'd1);
      @(negedge clk);
      post_checks("t2", v0, 1'b0);

      run_frame("t3", 40'h370018004E, 26, 70);

      // Second request mid-frame is dropped; the line sees exactly one START_US low pulse.
      f = make_frame(8'h2D, 8'h00, 8'h16, 8'h05, 8'h00);
      v0 = valid_cnt;
      exp_q.push_back(f);
      exp_data = f;
      lr0 = low_runs;
      pulse_start();
      fork
         sensor_frame(f, 1'b0, 26, 70, -1, ab);
         begin wait_us(1500); pulse_start(); end
      join
      wait_idle(2000, cyc);
      @(negedge clk);
      post_checks("t4", v0, 1'b1);
      check_eq("t4_low_runs", 40'(low_runs - lr0), 40'd1);
      check_eq("t4_low_len", 40'(last_low_len >= START_US * CYC_PER_US - 4 &&
                                 last_low_len <= START_US * CYC_PER_US + 6), 40'd1);

      // Reset while the DUT is measuring the high phase of bit 20.
      pulse_start();
      sensor_frame(40'hA5A5A5A5A5, 1'b0, 26, 70, 20, ab);
      check_eq("t5_reached_bit20", 40'(ab), 40'd1);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      exp_data = '0;
      check_eq("t5_rst_data", o_data, exp_data);
      check_eq("t5_rst_valid", 40'(o_valid), 40'd0);
      check_eq("t5_rst_busy", 40'(o_busy), 40'd0);
      check_eq("t5_rst_error", 40'(o_error), 40'd0);
      check_eq("t5_rst_line", 40'(dht_io), 40'd1);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      run_frame("t5_clean", make_frame(8'h40, 8'h00, 8'h19, 8'h00, 8'h00), 26, 70);

      run_frame("t6", 40'hFF00FF00FE, 26, 70);

      for (int k = 0; k < 2; k++) begin
         f = make_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                        ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00);
         run_frame($sformatf("rnd%0d", k), f, $urandom_range(18, 30), $urandom_range(58, 75));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
